// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer, instruction memory and decode/control.
// The master side is the sequencer; the slave side is the memory/decode environment.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic              instr_valid;
  logic              branch;
  logic              zero;
  logic              jump;
  logic              jr;
  logic [ADDR_W-1:0] imm_ext;
  logic [25:0]       jidx;
  logic [ADDR_W-1:0] rs_val;
  logic              halt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              misalign;
  logic              busy;

  modport master (
    input  start, imem_ack, branch, zero, jump, jr, imm_ext, jidx, rs_val, halt,
    output imem_req, imem_addr, instr_valid, pc, pc_plus4, misalign, busy
  );

  modport slave (
    output start, imem_ack, branch, zero, jump, jr, imm_ext, jidx, rs_val, halt,
    input  imem_req, imem_addr, instr_valid, pc, pc_plus4, misalign, busy
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the PC and runs a fetch/execute handshake
// against a variable-latency instruction memory.
module pc_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;
  logic              jr_misaligned;

  assign pc_plus4      = pc_q + ADDR_W'(4);
  assign jr_misaligned = bus.jr && (bus.rs_val[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    if (bus.jr) begin
      next_pc = bus.rs_val;
    end else if (bus.jump) begin
      next_pc = {pc_plus4[ADDR_W-1:28], bus.jidx, 2'b00};
    end else if (bus.branch && bus.zero) begin
      next_pc = pc_plus4 + (bus.imm_ext << 2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // A misaligned jr leaves pc untouched and parks in HALT regardless of halt.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) state_d = EXEC;
      end
      EXEC: begin
        if (jr_misaligned) begin
          misalign_d = 1'b1;
          state_d    = HALT;
        end else begin
          pc_d    = next_pc;
          state_d = bus.halt ? HALT : FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.instr_valid = (state_q == EXEC);
  assign bus.busy        = (state_q == FETCH) || (state_q == EXEC);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected fetch addresses go into a queue
// and a monitor compares them against every accepted fetch.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] expQ[$];
  logic [31:0] lastPc;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every fetch the DUT completes must match the next queued address.
  always @(negedge clk) begin
    if (rst_n && bus.imem_req && bus.imem_ack) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_fetch", bus.imem_addr, 32'hxxxx_xxxx);
      end else begin
        checkOutput("fetch_addr", bus.imem_addr, expQ.pop_front());
      end
    end
  end

  task automatic clearControls();
    bus.branch  = 1'b0;
    bus.zero    = 1'b0;
    bus.jump    = 1'b0;
    bus.jr      = 1'b0;
    bus.halt    = 1'b0;
    bus.imm_ext = '0;
    bus.jidx    = '0;
    bus.rs_val  = '0;
  endtask

  task automatic applyReset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.imem_ack = 1'b0;
    clearControls();
    #1;
    checkOutput("rst_pc", bus.pc, 32'h0);
    checkOutput("rst_pc_plus4", bus.pc_plus4, 32'h4);
    checkOutput("rst_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("rst_misalign", {31'b0, bus.misalign}, 32'h0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStart();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called at the start of a FETCH cycle; holds ack low for waits cycles first.
  task automatic applyFetch(input int waits, input logic [31:0] addr);
    expQ.push_back(addr);
    lastPc = addr;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      checkOutput("wait_req", {31'b0, bus.imem_req}, 32'h1);
      checkOutput("wait_addr", bus.imem_addr, addr);
      checkOutput("wait_valid", {31'b0, bus.instr_valid}, 32'h0);
      @(posedge clk);
      #1;
    end
    bus.imem_ack = 1'b1;
    @(negedge clk);
    checkOutput("fetch_valid", {31'b0, bus.instr_valid}, 32'h0);
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
  endtask

  task automatic applyExec(input logic br, input logic zr, input logic jmp, input logic jrr,
                           input logic hlt, input logic [31:0] imm, input logic [25:0] idx,
                           input logic [31:0] rs, input logic strayAck);
    bus.branch   = br;
    bus.zero     = zr;
    bus.jump     = jmp;
    bus.jr       = jrr;
    bus.halt     = hlt;
    bus.imm_ext  = imm;
    bus.jidx     = idx;
    bus.rs_val   = rs;
    bus.imem_ack = strayAck;
    @(negedge clk);
    checkOutput("exec_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("exec_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("exec_pc", bus.pc, lastPc);
    checkOutput("exec_pc_plus4", bus.pc_plus4, lastPc + 32'h4);
    @(posedge clk);
    #1;
    clearControls();
    bus.imem_ack = 1'b0;
  endtask

  task automatic checkHalted(input logic [31:0] pcExp, input logic misExp);
    bus.start    = 1'b1;
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("halt_req", {31'b0, bus.imem_req}, 32'h0);
      checkOutput("halt_valid", {31'b0, bus.instr_valid}, 32'h0);
      checkOutput("halt_busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("halt_pc", bus.pc, pcExp);
      checkOutput("halt_misalign", {31'b0, bus.misalign}, {31'b0, misExp});
      @(posedge clk);
      #1;
    end
    bus.start    = 1'b0;
    bus.imem_ack = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lastPc   = '0;
    applyReset();

    // Sequential run from reset.
    applyStart();
    checkOutput("start_busy", {31'b0, bus.busy}, 32'h1);
    applyFetch(0, 32'h0);
    applyExec(0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 0);
    applyFetch(0, 32'h4);
    applyExec(0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 0);
    applyFetch(0, 32'h8);
    applyExec(0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 0);

    // Branch taken backwards, then not taken.
    applyFetch(0, 32'hC);
    applyExec(0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h100, 0);
    applyFetch(0, 32'h100);
    applyExec(1, 1, 0, 0, 0, 32'hFFFF_FFFE, 26'h0, 32'h0, 0);
    applyFetch(0, 32'hFC);
    applyExec(0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h100, 0);
    applyFetch(0, 32'h100);
    applyExec(1, 0, 0, 0, 0, 32'hFFFF_FFFE, 26'h0, 32'h0, 0);

    // Jump beats branch; jr beats jump.
    applyFetch(0, 32'h104);
    applyExec(0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h1000_0040, 0);
    applyFetch(0, 32'h1000_0040);
    applyExec(1, 1, 1, 0, 0, 32'h4, 26'h000_0010, 32'h0, 0);
    applyFetch(0, 32'h1000_0040);
    applyExec(0, 0, 1, 1, 0, 32'h0, 26'h000_0010, 32'h200, 0);

    // Slow memory, stray ack in EXEC, then a waited fetch proves it was dropped.
    applyFetch(4, 32'h200);
    applyExec(0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 1);
    applyFetch(1, 32'h204);

    // Wrap-around and halt after the current instruction.
    applyExec(0, 0, 0, 1, 0, 32'h0, 26'h0, 32'hFFFF_FFFC, 0);
    applyFetch(0, 32'hFFFF_FFFC);
    applyExec(0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 0);
    applyFetch(0, 32'h0);
    applyExec(0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0, 0);
    checkHalted(32'h4, 1'b0);

    // Misaligned jr wins over halt=0 and freezes pc.
    applyReset();
    applyStart();
    applyFetch(0, 32'h0);
    applyExec(0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h203, 0);
    checkHalted(32'h0, 1'b1);
    applyReset();

    // Reset mid-FETCH drops req immediately.
    applyStart();
    @(negedge clk);
    checkOutput("midfetch_req", {31'b0, bus.imem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_fetch_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("abort_fetch_busy", {31'b0, bus.busy}, 32'h0);
    @(posedge clk);
    #1;
    applyReset();

    // Reset mid-EXEC: no pc update, valid drops at once.
    applyStart();
    applyFetch(0, 32'h0);
    bus.jr     = 1'b1;
    bus.rs_val = 32'h40;
    @(negedge clk);
    checkOutput("midexec_valid", {31'b0, bus.instr_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_exec_valid", {31'b0, bus.instr_valid}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("abort_exec_pc", bus.pc, 32'h0);
    applyReset();

    checkOutput("queue_drained", expQ.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
